// File: rtl/boid_pkg.sv
// rtl/boid_pkg.sv - shared field layout, FSM states and helpers for boid_state_mem
// Contents: NFIELDS, field_t (state-record field order), mem_state_t,
//           field_lsb() (bit offset of a field in a packed record),
//           idx_w() (boid index width, never below 1).
package boid_pkg;

    localparam int NFIELDS = 7;

    typedef enum logic [2:0] {
        FLD_X        = 3'd0,
        FLD_Y        = 3'd1,
        FLD_VX       = 3'd2,
        FLD_VY       = 3'd3,
        FLD_CLOSE_DX = 3'd4,
        FLD_CLOSE_DY = 3'd5,
        FLD_NCOUNT   = 3'd6
    } field_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SWAP = 2'd2
    } mem_state_t;

    function automatic int field_lsb(field_t f, int fw);
        return int'(f) * fw;
    endfunction

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/boid_state_mem_if.sv
// rtl/boid_state_mem_if.sv - controller <-> boid state memory read/writeback bus
// Signals: which_boid (shared read/write index), r_en_tot / r_en_itr (read requests),
//          wb_en / wb_data (masked writeback), rd_*_data / rd_*_valid (registered read returns).
// Modports: master = accelerator controller, slave = boid_state_mem.
interface boid_state_mem_if
    import boid_pkg::*;
#(
    parameter int IW = 1,
    parameter int FW = 16
) ();

    logic [IW-1:0]         which_boid;
    logic                  r_en_tot;
    logic                  r_en_itr;
    logic [NFIELDS-1:0]    wb_en;
    logic [NFIELDS*FW-1:0] wb_data;
    logic [NFIELDS*FW-1:0] rd_tot_data;
    logic                  rd_tot_valid;
    logic [NFIELDS*FW-1:0] rd_itr_data;
    logic                  rd_itr_valid;

    modport master (
        output which_boid, r_en_tot, r_en_itr, wb_en, wb_data,
        input  rd_tot_data, rd_tot_valid, rd_itr_data, rd_itr_valid
    );

    modport slave (
        input  which_boid, r_en_tot, r_en_itr, wb_en, wb_data,
        output rd_tot_data, rd_tot_valid, rd_itr_data, rd_itr_valid
    );

endinterface

// File: rtl/boid_bank.sv
// rtl/boid_bank.sv - one NUM_BOIDS x 7-field state bank with masked write and two read ports
// Ports: clk, reset (sync, active-high, reloads the spacing image),
//        we / w_idx / w_mask / w_data (masked field write, caller qualifies the index),
//        ra_idx -> ra_data (full record, zero when out of range),
//        rb_idx -> rb_x / rb_y (position only, zero when out of range).
module boid_bank
    import boid_pkg::*;
#(
    parameter int NUM_BOIDS    = 2,
    parameter int FW           = 16,
    parameter int INIT_SPACING = 40,
    parameter int IW           = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [IW-1:0]         w_idx,
    input  logic [NFIELDS-1:0]    w_mask,
    input  logic [NFIELDS*FW-1:0] w_data,
    input  logic [IW-1:0]         ra_idx,
    output logic [NFIELDS*FW-1:0] ra_data,
    input  logic [IW-1:0]         rb_idx,
    output logic [FW-1:0]         rb_x,
    output logic [FW-1:0]         rb_y
);

    localparam logic [IW:0] NB = (IW+1)'(NUM_BOIDS);

    logic [NFIELDS*FW-1:0] mem [NUM_BOIDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BOIDS; i++) begin
                mem[i] <= '0;
                mem[i][field_lsb(FLD_X, FW) +: FW] <= FW'(i * INIT_SPACING);
                mem[i][field_lsb(FLD_Y, FW) +: FW] <= FW'(i * INIT_SPACING);
            end
        end else if (we) begin
            for (int k = 0; k < NFIELDS; k++) begin
                if (w_mask[k]) begin
                    mem[w_idx][k*FW +: FW] <= w_data[k*FW +: FW];
                end
            end
        end
    end

    always_comb begin
        ra_data = '0;
        if ({1'b0, ra_idx} < NB) begin
            ra_data = mem[ra_idx];
        end
    end

    always_comb begin
        rb_x = '0;
        rb_y = '0;
        if ({1'b0, rb_idx} < NB) begin
            rb_x = mem[rb_idx][field_lsb(FLD_X, FW) +: FW];
            rb_y = mem[rb_idx][field_lsb(FLD_Y, FW) +: FW];
        end
    end

endmodule

// File: rtl/boid_state_mem.sv
// rtl/boid_state_mem.sv - ping-pong per-boid state memory with display refill scan
// Ports: clk, reset (sync, active-high), bus (boid_state_mem_if.slave: reads from the
//        front bank, masked writebacks to the back bank), frame_start (refill request),
//        disp_idx / disp_x / disp_y / disp_valid (scan output), is_refilling, bank_sel.
// Build option: BOID_MEM_DISP_PORT_EN enables the SCAN state and the display outputs;
//        without it frame_start is ignored and the display outputs are tied low.
module boid_state_mem
    import boid_pkg::*;
#(
    parameter int NUM_BOIDS    = 2,
    parameter int FW           = 16,
    parameter int INIT_SPACING = 40,
    localparam int IW          = idx_w(NUM_BOIDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    boid_state_mem_if.slave       bus,
    input  logic                  frame_start,
    output logic [IW-1:0]         disp_idx,
    output logic [FW-1:0]         disp_x,
    output logic [FW-1:0]         disp_y,
    output logic                  disp_valid,
    output logic                  is_refilling,
    output logic                  bank_sel
);

    localparam logic [IW:0] NB = (IW+1)'(NUM_BOIDS);
`ifdef BOID_MEM_DISP_PORT_EN
    localparam logic [IW-1:0] LAST = IW'(NUM_BOIDS - 1);
`endif

    mem_state_t            state_q, state_d;
    logic [NUM_BOIDS-1:0]  written_q, wr_onehot;
    logic                  wr_hit, wr_to_b1;
    logic [NFIELDS*FW-1:0] b0_ra, b1_ra, front_rec;
    logic [FW-1:0]         b0_x, b0_y, b1_x, b1_y;
    logic [IW-1:0]         disp_rd_idx;

    assign wr_hit = (bus.wb_en != '0) && ({1'b0, bus.which_boid} < NB);

    // During SWAP the write must land in the bank that becomes the back bank
    // once bank_sel toggles at the end of this cycle, i.e. the current front.
    assign wr_to_b1  = (state_q == SWAP) ? bank_sel : ~bank_sel;
    assign front_rec = bank_sel ? b1_ra : b0_ra;

    always_comb begin
        wr_onehot = '0;
        if (wr_hit) begin
            wr_onehot[bus.which_boid] = 1'b1;
        end
    end

    boid_bank #(.NUM_BOIDS(NUM_BOIDS), .FW(FW), .INIT_SPACING(INIT_SPACING), .IW(IW)) u_bank0 (
        .clk(clk), .reset(reset), .we(wr_hit & ~wr_to_b1), .w_idx(bus.which_boid),
        .w_mask(bus.wb_en), .w_data(bus.wb_data), .ra_idx(bus.which_boid), .ra_data(b0_ra),
        .rb_idx(disp_rd_idx), .rb_x(b0_x), .rb_y(b0_y)
    );

    boid_bank #(.NUM_BOIDS(NUM_BOIDS), .FW(FW), .INIT_SPACING(INIT_SPACING), .IW(IW)) u_bank1 (
        .clk(clk), .reset(reset), .we(wr_hit & wr_to_b1), .w_idx(bus.which_boid),
        .w_mask(bus.wb_en), .w_data(bus.wb_data), .ra_idx(bus.which_boid), .ra_data(b1_ra),
        .rb_idx(disp_rd_idx), .rb_x(b1_x), .rb_y(b1_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bank_sel  <= 1'b0;
            written_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SWAP) begin
                bank_sel <= ~bank_sel;
            end
            // A write issued in the SWAP cycle is the first entry of the new pass.
            written_q <= ((state_q == SWAP) ? '0 : written_q) | wr_onehot;
        end
    end

    // A full written mask outranks frame_start; a full mask during SCAN
    // is held off until the scan has returned to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (&written_q) begin
                    state_d = SWAP;
                end
`ifdef BOID_MEM_DISP_PORT_EN
                else if (frame_start) begin
                    state_d = SCAN;
                end
`endif
            end
`ifdef BOID_MEM_DISP_PORT_EN
            SCAN: begin
                if (disp_idx == LAST) begin
                    state_d = IDLE;
                end
            end
`endif
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_tot_valid <= 1'b0;
            bus.rd_itr_valid <= 1'b0;
            bus.rd_tot_data  <= '0;
            bus.rd_itr_data  <= '0;
        end else begin
            bus.rd_tot_valid <= bus.r_en_tot;
            bus.rd_itr_valid <= bus.r_en_itr;
            if (bus.r_en_tot) begin
                bus.rd_tot_data <= front_rec;
            end
            if (bus.r_en_itr) begin
                bus.rd_itr_data <= front_rec;
            end
        end
    end

`ifdef BOID_MEM_DISP_PORT_EN
    assign disp_rd_idx = disp_idx;

    // disp_x/disp_y/disp_valid trail disp_idx by one cycle; is_refilling
    // covers the whole scan plus the trailing data cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_idx     <= '0;
            disp_x       <= '0;
            disp_y       <= '0;
            disp_valid   <= 1'b0;
            is_refilling <= 1'b0;
        end else begin
            disp_valid   <= (state_q == SCAN);
            is_refilling <= (state_q == SCAN) || (state_d == SCAN);
            if (state_q == SCAN) begin
                disp_x <= bank_sel ? b1_x : b0_x;
                disp_y <= bank_sel ? b1_y : b0_y;
            end
            if (state_q == IDLE && state_d == SCAN) begin
                disp_idx <= '0;
            end else if (state_q == SCAN && disp_idx != LAST) begin
                disp_idx <= disp_idx + 1'b1;
            end
        end
    end
`else
    assign disp_rd_idx  = '0;
    assign disp_idx     = '0;
    assign disp_x       = '0;
    assign disp_y       = '0;
    assign disp_valid   = 1'b0;
    assign is_refilling = 1'b0;

    logic unused_disp;
    assign unused_disp = ^{frame_start, b0_x, b0_y, b1_x, b1_y};
`endif

endmodule

// File: tb/tb_boid_state_mem.sv
// tb/tb_boid_state_mem.sv - self-checking bench for boid_state_mem (NUM_BOIDS=3 so index 3 is out of range)
module tb_boid_state_mem;
    import boid_pkg::*;

    localparam int N  = 3;
    localparam int FW = 16;
    localparam int SP = 40;
    localparam int IW = 2;
    localparam int NF = 7;

    logic clk = 1'b0;
    logic reset;
    logic frame_start;
    logic [IW-1:0] disp_idx;
    logic [FW-1:0] disp_x, disp_y;
    logic disp_valid, is_refilling, bank_sel;

    always #5 clk = ~clk;

    boid_state_mem_if #(.IW(IW), .FW(FW)) bus ();

    boid_state_mem #(.NUM_BOIDS(N), .FW(FW), .INIT_SPACING(SP)) dut (
        .clk(clk), .reset(reset), .bus(bus), .frame_start(frame_start),
        .disp_idx(disp_idx), .disp_x(disp_x), .disp_y(disp_y), .disp_valid(disp_valid),
        .is_refilling(is_refilling), .bank_sel(bank_sel)
    );

    int checks = 0;
    int errors = 0;

    // Reference: two banks of N records of NF fields, a front selector and a written set.
    logic [FW-1:0] mdl [2][N][NF];
    int            msel;
    bit            mwritten [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.r_en_tot = 1'b0;
        bus.r_en_itr = 1'b0;
        bus.wb_en    = '0;
        frame_start  = 1'b0;
    endtask

    task automatic mdl_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++)
                for (int k = 0; k < NF; k++)
                    mdl[b][i][k] = (k < 2) ? FW'(i * SP) : '0;
        msel = 0;
        for (int i = 0; i < N; i++) mwritten[i] = 0;
    endtask

    task automatic mdl_write(int idx, logic [NF-1:0] mask, logic [NF*FW-1:0] data);
        if (mask != 0 && idx < N) begin
            for (int k = 0; k < NF; k++)
                if (mask[k]) mdl[1-msel][idx][k] = data[k*FW +: FW];
            mwritten[idx] = 1;
        end
    endtask

    task automatic mdl_swap();
        msel = 1 - msel;
        for (int i = 0; i < N; i++) mwritten[i] = 0;
    endtask

    function automatic bit mdl_full();
        for (int i = 0; i < N; i++) if (!mwritten[i]) return 0;
        return 1;
    endfunction

    function automatic logic [N-1:0] mdl_wvec();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = mwritten[i];
        return v;
    endfunction

    function automatic logic [NF*FW-1:0] front_rec(int idx);
        logic [NF*FW-1:0] r = '0;
        if (idx < N)
            for (int k = 0; k < NF; k++) r[k*FW +: FW] = mdl[msel][idx][k];
        return r;
    endfunction

    function automatic logic [NF*FW-1:0] rand_data();
        return (NF*FW)'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic write_boid(int idx, logic [NF-1:0] mask, logic [NF*FW-1:0] data);
        bus.which_boid = IW'(idx);
        bus.wb_en      = mask;
        bus.wb_data    = data;
        tick();
        bus.wb_en = '0;
        mdl_write(idx, mask, data);
    endtask

    // Writes every still-unwritten boid, then lets the two-cycle swap complete.
    task automatic fill_and_swap();
        for (int i = 0; i < N; i++)
            if (!mwritten[i]) write_boid(i, 7'($urandom_range(1, 127)), rand_data());
        tick();
        tick();
        mdl_swap();
        checks++;
        if (bank_sel !== msel[0]) begin
            errors++;
            $display("FAIL fill_swap_sel got %0b exp %0b", bank_sel, msel[0]);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.which_boid = '0;
        bus.wb_data    = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        mdl_reset();
        checks++;
        if ({bank_sel, bus.rd_tot_valid, bus.rd_itr_valid, disp_valid, is_refilling} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 00000",
                     {bank_sel, bus.rd_tot_valid, bus.rd_itr_valid, disp_valid, is_refilling});
        end
        checks++;
        if (dut.written_q !== '0) begin
            errors++;
            $display("FAIL reset_written got %b exp 000", dut.written_q);
        end
        bus.which_boid = 2'd1;
        bus.r_en_tot   = 1'b1;
        tick();
        bus.r_en_tot = 1'b0;
        checks++;
        if (bus.rd_tot_valid !== 1'b1 || bus.rd_itr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_read_valid got tot=%b itr=%b exp tot=1 itr=0",
                     bus.rd_tot_valid, bus.rd_itr_valid);
        end
        checks++;
        if (bus.rd_tot_data !== {80'h0, 16'd40, 16'd40}) begin
            errors++;
            $display("FAIL reset_read_boid1 got %h exp %h", bus.rd_tot_data, {80'h0, 16'd40, 16'd40});
        end
        tick();
        checks++;
        if (bus.rd_tot_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_valid_pulse got %b exp 0", bus.rd_tot_valid);
        end
    endtask

    task automatic test_write_swap();
        logic [NF*FW-1:0] d;
        d = rand_data();
        d[FW-1:0] = 16'd100;
        write_boid(0, 7'b0011111, d);
        bus.which_boid = 2'd0;
        bus.r_en_tot   = 1'b1;
        tick();
        bus.r_en_tot = 1'b0;
        checks++;
        if (bus.rd_tot_data[FW-1:0] !== 16'd0 || bus.rd_tot_data !== front_rec(0)) begin
            errors++;
            $display("FAIL front_unchanged got %h exp %h", bus.rd_tot_data, front_rec(0));
        end
        write_boid(1, 7'b1111111, rand_data());
        write_boid(2, 7'b0000001, rand_data());
        tick();
        checks++;
        if (bank_sel !== 1'b0) begin
            errors++;
            $display("FAIL swap_not_early got %b exp 0", bank_sel);
        end
        tick();
        mdl_swap();
        checks++;
        if (bank_sel !== 1'b1) begin
            errors++;
            $display("FAIL swap_toggle got %b exp 1", bank_sel);
        end
        checks++;
        if (dut.written_q !== '0) begin
            errors++;
            $display("FAIL swap_clears_written got %b exp 000", dut.written_q);
        end
        bus.which_boid = 2'd0;
        bus.r_en_itr   = 1'b1;
        tick();
        bus.r_en_itr = 1'b0;
        checks++;
        if (bus.rd_itr_data[FW-1:0] !== 16'd100 || bus.rd_itr_data !== front_rec(0)) begin
            errors++;
            $display("FAIL read_after_swap got %h exp %h", bus.rd_itr_data, front_rec(0));
        end
    endtask

    task automatic test_no_swap();
        int sel0;
        sel0 = msel;
        for (int r = 0; r < 3; r++) write_boid(0, 7'($urandom_range(1, 127)), rand_data());
        for (int r = 0; r < 4; r++) tick();
        checks++;
        if (dut.written_q !== 3'b001 || bank_sel !== sel0[0]) begin
            errors++;
            $display("FAIL no_swap got written=%b sel=%b exp written=001 sel=%b",
                     dut.written_q, bank_sel, sel0[0]);
        end
        fill_and_swap();
        bus.which_boid = 2'd0;
        bus.r_en_tot   = 1'b1;
        tick();
        bus.r_en_tot = 1'b0;
        checks++;
        if (bus.rd_tot_data !== front_rec(0)) begin
            errors++;
            $display("FAIL last_write_wins got %h exp %h", bus.rd_tot_data, front_rec(0));
        end
    endtask

    task automatic test_out_of_range();
        bus.which_boid = 2'd3;
        bus.r_en_tot   = 1'b1;
        bus.r_en_itr   = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.rd_tot_valid !== 1'b1 || bus.rd_itr_valid !== 1'b1 ||
            bus.rd_tot_data !== '0 || bus.rd_itr_data !== '0) begin
            errors++;
            $display("FAIL oob_read got v=%b%b tot=%h itr=%h exp v=11 data 0",
                     bus.rd_tot_valid, bus.rd_itr_valid, bus.rd_tot_data, bus.rd_itr_data);
        end
        write_boid(3, 7'b1111111, rand_data());
        checks++;
        if (dut.written_q !== mdl_wvec()) begin
            errors++;
            $display("FAIL oob_write_written got %b exp %b", dut.written_q, mdl_wvec());
        end
        fill_and_swap();
        for (int i = 0; i < N; i++) begin
            bus.which_boid = IW'(i);
            bus.r_en_tot   = 1'b1;
            tick();
            bus.r_en_tot = 1'b0;
            checks++;
            if (bus.rd_tot_data !== front_rec(i)) begin
                errors++;
                $display("FAIL oob_write_ignored boid %0d got %h exp %h", i, bus.rd_tot_data, front_rec(i));
            end
        end
    endtask

`ifdef BOID_MEM_DISP_PORT_EN
    task automatic test_scan();
        int nref, nval;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        nref = is_refilling ? 1 : 0;
        nval = 0;
        checks++;
        if (is_refilling !== 1'b1 || disp_idx !== 2'd0 || disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL scan_start got ref=%b idx=%0d val=%b exp 1 0 0", is_refilling, disp_idx, disp_valid);
        end
        for (int k = 1; k <= N + 1; k++) begin
            tick();
            nref += is_refilling ? 1 : 0;
            nval += disp_valid ? 1 : 0;
            if (k <= N) begin
                checks++;
                if (disp_valid !== 1'b1 || disp_x !== mdl[msel][k-1][0] || disp_y !== mdl[msel][k-1][1] ||
                    disp_idx !== IW'((k < N) ? k : N - 1)) begin
                    errors++;
                    $display("FAIL scan_step %0d got val=%b idx=%0d x=%0d y=%0d exp 1 %0d %0d %0d", k,
                             disp_valid, disp_idx, disp_x, disp_y, (k < N) ? k : N - 1,
                             mdl[msel][k-1][0], mdl[msel][k-1][1]);
                end
            end
        end
        checks++;
        if (nref != N + 1 || nval != N || is_refilling !== 1'b0) begin
            errors++;
            $display("FAIL scan_lengths got ref=%0d val=%0d exp ref=%0d val=%0d", nref, nval, N + 1, N);
        end
    endtask

    task automatic test_scan_fill();
        int sel0;
        sel0 = msel;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 1; k <= N; k++) begin
            write_boid(k - 1, 7'($urandom_range(1, 127)), rand_data());
            checks++;
            if (bank_sel !== sel0[0] || disp_valid !== 1'b1 || disp_x !== mdl[sel0][k-1][0]) begin
                errors++;
                $display("FAIL scan_fill_step %0d got sel=%b val=%b x=%0d exp sel=%b val=1 x=%0d", k,
                         bank_sel, disp_valid, disp_x, sel0[0], mdl[sel0][k-1][0]);
            end
        end
        tick();
        checks++;
        if (bank_sel !== sel0[0] || is_refilling !== 1'b0 || disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL scan_fill_hold got sel=%b ref=%b val=%b exp sel=%b 0 0",
                     bank_sel, is_refilling, disp_valid, sel0[0]);
        end
        tick();
        mdl_swap();
        checks++;
        if (bank_sel !== msel[0]) begin
            errors++;
            $display("FAIL scan_fill_swap got %b exp %b", bank_sel, msel[0]);
        end
    endtask

    task automatic test_reset_midscan();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdl_reset();
        checks++;
        if ({is_refilling, disp_valid, bank_sel} !== 3'b0 || disp_idx !== '0) begin
            errors++;
            $display("FAIL reset_midscan got ref=%b val=%b sel=%b idx=%0d exp zeros",
                     is_refilling, disp_valid, bank_sel, disp_idx);
        end
        bus.which_boid = 2'd2;
        bus.r_en_tot   = 1'b1;
        tick();
        bus.r_en_tot = 1'b0;
        checks++;
        if (bus.rd_tot_data !== {80'h0, 16'd80, 16'd80}) begin
            errors++;
            $display("FAIL reset_midscan_image got %h exp %h", bus.rd_tot_data, {80'h0, 16'd80, 16'd80});
        end
    endtask
`else
    task automatic test_scan_disabled();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({is_refilling, disp_valid} !== 2'b0 || disp_idx !== '0 || disp_x !== '0 || disp_y !== '0) begin
                errors++;
                $display("FAIL scan_disabled cycle %0d got ref=%b val=%b idx=%0d exp zeros",
                         k, is_refilling, disp_valid, disp_idx);
            end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        int pend;
        int idx;
        bit et, ei;
        logic [NF*FW-1:0] exp_rec;
        logic [NF-1:0] mask;
        logic [NF*FW-1:0] data;
        pend = 0;
        for (int it = 0; it < 300; it++) begin
            idx  = $urandom_range(0, 3);
            et   = 1'($urandom_range(0, 1));
            ei   = 1'($urandom_range(0, 1));
            mask = (pend == 0 && $urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
            data = rand_data();
            bus.which_boid = IW'(idx);
            bus.r_en_tot   = et;
            bus.r_en_itr   = ei;
            bus.wb_en      = mask;
            bus.wb_data    = data;
            exp_rec = front_rec(idx);
            tick();
            if (pend > 0) begin
                pend--;
                if (pend == 0) mdl_swap();
            end else begin
                mdl_write(idx, mask, data);
                if (mdl_full()) pend = 2;
            end
            checks++;
            if (bus.rd_tot_valid !== et || bus.rd_itr_valid !== ei || bank_sel !== msel[0] ||
                (et && bus.rd_tot_data !== exp_rec) || (ei && bus.rd_itr_data !== exp_rec)) begin
                errors++;
                $display("FAIL random it %0d idx %0d got v=%b%b sel=%b tot=%h itr=%h exp v=%b%b sel=%b data=%h",
                         it, idx, bus.rd_tot_valid, bus.rd_itr_valid, bank_sel, bus.rd_tot_data,
                         bus.rd_itr_data, et, ei, msel[0], exp_rec);
            end
        end
        idle_inputs();
        while (pend > 0) begin
            tick();
            pend--;
            if (pend == 0) mdl_swap();
        end
    endtask

    initial begin
        test_reset();
        test_write_swap();
        test_no_swap();
        test_out_of_range();
`ifdef BOID_MEM_DISP_PORT_EN
        test_scan();
        test_scan_fill();
        test_random();
        test_reset_midscan();
`else
        test_scan_disabled();
        test_random();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
